// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one stop bit.
// Each bit is held for Prescale clock cycles, captured when the word is accepted.
module uart_tx_serializer #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [width-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [4:0]       Prescale,
  output logic             TX_OUT,
  output logic             busy
);

  localparam int IDX_W = (width > 1) ? $clog2(width) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [4:0]       edge_cnt;
  logic [4:0]       prescale_r;
  logic [IDX_W-1:0] bit_idx;
  logic [width-1:0] shift_reg;
  logic [width-1:0] shift_nxt;
  logic             par_en_r;
  logic             par_bit;
  logic             bit_done;

  assign bit_done  = (edge_cnt == prescale_r);
  assign shift_nxt = shift_reg >> 1;

  // The line level for the next bit is loaded on the edge that ends the current one.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      edge_cnt   <= 5'd0;
      prescale_r <= 5'd0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_en_r   <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            shift_reg  <= P_DATA;
            par_en_r   <= PAR_EN;
            par_bit    <= (^P_DATA) ^ PAR_TYP;
            prescale_r <= (Prescale == 5'd0) ? 5'd1 : Prescale;
            edge_cnt   <= 5'd1;
            bit_idx    <= '0;
            state      <= START;
            TX_OUT     <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            TX_OUT   <= shift_reg[0];
            edge_cnt <= 5'd1;
            bit_idx  <= '0;
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            edge_cnt <= 5'd1;
            if (bit_idx == LAST_IDX) begin
              if (par_en_r) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              shift_reg <= shift_nxt;
              TX_OUT    <= shift_nxt[0];
            end
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            TX_OUT   <= 1'b1;
            edge_cnt <= 5'd1;
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            edge_cnt <= 5'd0;
            bit_idx  <= '0;
          end else begin
            edge_cnt <= edge_cnt + 5'd1;
          end
        end
        default: begin
          state    <= IDLE;
          TX_OUT   <= 1'b1;
          busy     <= 1'b0;
          edge_cnt <= 5'd0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: a queue-based frame model is compared every cycle,
// plus literal line sequences and busy lengths for hand-worked frames.
module tb_uart_tx_serializer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] P_DATA = '0;
  logic         Data_Valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [4:0]   Prescale = 5'd0;
  logic         TX_OUT;
  logic         busy;

  int checks = 0;
  int fails = 0;

  bit   exp_q[$];
  logic exp_tx = 1'b1;
  logic exp_busy = 1'b0;

  uart_tx_serializer #(.width(W)) dut (
    .CLK(CLK), .Reset(Reset), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // A frame is a list of line levels, each repeated for the effective prescale.
  task automatic pushFrame(input logic [W-1:0] d, input logic en, input logic typ,
                           input logic [4:0] pre);
    int p;
    bit lv[$];
    p = (pre == 5'd0) ? 1 : int'(pre);
    lv.push_back(1'b0);
    for (int i = 0; i < W; i++) lv.push_back(d[i]);
    if (en) lv.push_back((^d) ^ typ);
    lv.push_back(1'b1);
    foreach (lv[k]) repeat (p) exp_q.push_back(lv[k]);
  endtask

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      exp_q.delete();
      exp_tx = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (!exp_busy && Data_Valid) pushFrame(P_DATA, PAR_EN, PAR_TYP, Prescale);
      if (exp_q.size() > 0) begin
        exp_tx = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    checks += 2;
    if (TX_OUT !== exp_tx) begin
      fails++;
      $display("[TB] FAIL model_tx t=%0t: got %b expected %b", $time, TX_OUT, exp_tx);
    end
    if (busy !== exp_busy) begin
      fails++;
      $display("[TB] FAIL model_busy t=%0t: got %b expected %b", $time, busy, exp_busy);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic en, input logic typ,
                               input logic [4:0] pre);
    @(negedge CLK);
    P_DATA = d;
    PAR_EN = en;
    PAR_TYP = typ;
    Prescale = pre;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  // Samples the first cycle of each bit while busy; optionally disturbs inputs mid-frame.
  task automatic captureFrame(input int p, input bit disturb, output logic [15:0] lv,
                              output int n);
    n = 0;
    lv = '0;
    while (busy === 1'b1 && n < 1000) begin
      if ((n % p) == 0 && (n / p) < 16) lv[n / p] = TX_OUT;
      if (disturb && n == 3) begin
        Data_Valid = 1'b1;
        P_DATA = 8'h3C;
        PAR_TYP = ~PAR_TYP;
        Prescale = 5'd7;
      end else if (disturb && n == 4) begin
        Data_Valid = 1'b0;
      end
      n++;
      @(negedge CLK);
    end
    checkOutput("frame_timeout", 32'(n >= 1000), 32'd0);
  endtask

  initial begin
    logic [15:0] lv;
    int n;
    int gap;

    #1 Reset = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_tx", 32'(TX_OUT), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);

    applyStimulus(8'hA5, 1'b1, 1'b0, 5'd4);
    captureFrame(4, 1'b0, lv, n);
    checkOutput("a5_even_levels", 32'(lv[10:0]), 32'(11'b10101001010));
    checkOutput("a5_even_busy", n, 44);

    applyStimulus(8'hA5, 1'b1, 1'b1, 5'd4);
    captureFrame(4, 1'b0, lv, n);
    checkOutput("a5_odd_levels", 32'(lv[10:0]), 32'(11'b11101001010));
    checkOutput("a5_odd_busy", n, 44);

    applyStimulus(8'hFF, 1'b0, 1'b0, 5'd1);
    captureFrame(1, 1'b0, lv, n);
    checkOutput("ff_p1_levels", 32'(lv[10:0]), 32'(11'b01111111110));
    checkOutput("ff_p1_busy", n, 10);

    applyStimulus(8'hFF, 1'b0, 1'b0, 5'd0);
    captureFrame(1, 1'b0, lv, n);
    checkOutput("ff_p0_levels", 32'(lv[10:0]), 32'(11'b01111111110));
    checkOutput("ff_p0_busy", n, 10);

    applyStimulus(8'h81, 1'b1, 1'b0, 5'd2);
    captureFrame(2, 1'b1, lv, n);
    checkOutput("x81_levels", 32'(lv[10:0]), 32'(11'b10100000010));
    checkOutput("x81_busy", n, 22);
    repeat (5) begin
      checkOutput("x3c_not_sent", 32'(busy), 32'd0);
      @(negedge CLK);
    end

    // Valid held high: two frames with exactly one idle cycle between them.
    P_DATA = 8'h55;
    PAR_EN = 1'b0;
    Prescale = 5'd2;
    Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hAA;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    checkOutput("b2b_first_len", n, 20);
    gap = 0;
    while (busy !== 1'b1 && gap < 100) begin
      gap++;
      @(negedge CLK);
    end
    checkOutput("b2b_gap", gap, 1);
    Data_Valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    checkOutput("b2b_second_len", n, 20);

    // Asynchronous reset in the middle of the data bits.
    applyStimulus(8'h00, 1'b0, 1'b0, 5'd4);
    repeat (10) @(negedge CLK);
    checkOutput("pre_reset_tx", 32'(TX_OUT), 32'd0);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async_reset_tx", 32'(TX_OUT), 32'd1);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    #2 Reset = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      checkOutput("post_reset_tx", 32'(TX_OUT), 32'd1);
      checkOutput("post_reset_busy", 32'(busy), 32'd0);
    end

    repeat (1500) begin
      @(negedge CLK);
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA = W'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      Prescale = 5'($urandom_range(0, 5));
    end
    @(negedge CLK);
    Data_Valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    checkOutput("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
